vga_sram_rgb_fetch: RTL and testbench

Prefetching SRAM reader that feeds the VGA output path with 24-bit RGB pixels for the 320x240 view area. Streams packed RGB words (3 words per 2 pixels) from a fixed SRAM base address through an 8-word buffer. Unpacks them into one pixel per request from the VGA pixel timing logic. Sits between the SRAM arbiter (read-only master) and the VGA controller; the colour-conversion stages write the image that this block displays.

---
 rtl/vga_sram_rgb_fetch.sv | 118 +++++++++++
 tb/tb_vga_sram_rgb_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vga_sram_rgb_fetch.sv
// vga_sram_rgb_fetch: prefetches packed RGB words from SRAM into an 8-word buffer and unpacks one pixel per request.
// Defining VGA_FETCH_UNDERFLOW_CNT_EN adds a saturating underflow_count_o port.
module vga_sram_rgb_fetch #(
    parameter logic [17:0] BASE_ADDR = 18'd146944,
    parameter int          NUM_WORDS = 115200
) (
    input  logic        clock_i,
    input  logic        resetn_i,
    input  logic        frame_start_i,
    input  logic        pixel_req_i,
    input  logic [15:0] sram_read_data_i,
    output logic [17:0] sram_address_o,
    output logic        sram_we_n_o,
    output logic [23:0] rgb_o,
    output logic        busy_o,
    output logic        underflow_o
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_count_o
`endif
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [17:0] addr_q, addr_d;
    logic [16:0] issued_q, issued_d;
    logic [1:0]  vld_q, vld_d;
    logic [2:0]  wr_q, wr_d, rd_q, rd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        odd_q, odd_d;
    logic [7:0]  r1_q, r1_d;
    logic [23:0] rgb_q, rgb_d;
    logic        uf_q, uf_d;
    logic [15:0] buf_q [8];

    logic [3:0]  in_flight, need;
    logic [15:0] w0, w1;
    logic        live, issue, last_issue, push, pop, uf_ev;

    assign in_flight  = {3'd0, vld_q[0]} + {3'd0, vld_q[1]};
    assign need       = odd_q ? 4'd1 : 4'd2;
    assign live       = state_q != S_IDLE;
    assign issue      = !frame_start_i && state_q == S_FETCH && (cnt_q + in_flight < 4'd8);
    assign last_issue = issue && issued_q == 17'(NUM_WORDS - 1);
    assign push       = vld_q[1];
    assign pop        = !frame_start_i && pixel_req_i && live && cnt_q >= need;
    assign uf_ev      = !frame_start_i && pixel_req_i && live && cnt_q < need;
    assign w0         = buf_q[rd_q];
    assign w1         = buf_q[rd_q + 3'd1];

    always_comb begin
        cnt_d    = frame_start_i ? 4'd0 : cnt_q + {3'd0, push} - (pop ? need : 4'd0);
        wr_d     = frame_start_i ? 3'd0 : wr_q + {2'd0, push};
        rd_d     = frame_start_i ? 3'd0 : rd_q + (pop ? need[2:0] : 3'd0);
        vld_d    = frame_start_i ? 2'b00 : {vld_q[0], issue};
        addr_d   = frame_start_i ? BASE_ADDR : (issue && !last_issue) ? addr_q + 18'd1 : addr_q;
        issued_d = frame_start_i ? 17'd0 : issue ? issued_q + 17'd1 : issued_q;
        odd_d    = frame_start_i ? 1'b0 : pop ? !odd_q : odd_q;
        // Even pixel takes {R0,G0} and B0, keeping R1 for the following odd pixel
        r1_d     = (pop && !odd_q) ? w1[7:0] : r1_q;
        rgb_d    = pop ? (odd_q ? {r1_q, w0} : {w0, w1[15:8]}) :
                   (pixel_req_i && !frame_start_i) ? 24'd0 : rgb_q;
        uf_d     = frame_start_i ? 1'b0 : uf_q | uf_ev;
        state_d  = frame_start_i ? S_FETCH :
                   last_issue ? S_DRAIN :
                   (state_q == S_DRAIN && cnt_d == 4'd0 && !vld_q[0]) ? S_IDLE : state_q;
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= S_IDLE;
            addr_q   <= BASE_ADDR;
            issued_q <= 17'd0;
            vld_q    <= 2'b00;
            wr_q     <= 3'd0;
            rd_q     <= 3'd0;
            cnt_q    <= 4'd0;
            odd_q    <= 1'b0;
            r1_q     <= 8'd0;
            rgb_q    <= 24'd0;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            vld_q    <= vld_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            odd_q    <= odd_d;
            r1_q     <= r1_d;
            rgb_q    <= rgb_d;
            uf_q     <= uf_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) buf_q[wr_q] <= sram_read_data_i;
    end

`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
    logic [15:0] ufc_q, ufc_d;
    assign ufc_d = frame_start_i ? 16'd0 : (uf_ev && ufc_q != 16'hFFFF) ? ufc_q + 16'd1 : ufc_q;
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) ufc_q <= 16'd0;
        else ufc_q <= ufc_d;
    end
    assign underflow_count_o = ufc_q;
`endif

    assign sram_address_o = addr_q;
    assign sram_we_n_o    = 1'b1;
    assign rgb_o          = rgb_q;
    assign busy_o         = live;
    assign underflow_o    = uf_q;
endmodule

// File: tb/tb_vga_sram_rgb_fetch.sv
// tb_vga_sram_rgb_fetch: directed bench with a byte-stream pixel model and per-cycle output comparison.
module tb_vga_sram_rgb_fetch;
    localparam logic [17:0] BASE = 18'd146944;
    localparam int W    = 300;
    localparam int NPIX = W * 2 / 3;

    logic clk = 1'b0, resetn = 1'b1, frame_start = 1'b0, pixel_req = 1'b0, req_under = 1'b0;
    logic [15:0] rdata, ufc;
    logic [17:0] addr;
    logic        we_n, busy, uf;
    logic [23:0] rgb;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    vga_sram_rgb_fetch #(.BASE_ADDR(BASE), .NUM_WORDS(W)) dut (
        .clock_i(clk), .resetn_i(resetn), .frame_start_i(frame_start), .pixel_req_i(pixel_req),
        .sram_read_data_i(rdata), .sram_address_o(addr), .sram_we_n_o(we_n), .rgb_o(rgb),
        .busy_o(busy), .underflow_o(uf)
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
        , .underflow_count_o(ufc)
`endif
    );
`ifndef VGA_FETCH_UNDERFLOW_CNT_EN
    assign ufc = 16'd0;
`endif

    // SRAM with two-cycle read latency
    logic [15:0] mem [W];
    logic [15:0] d1 = 16'd0, d2 = 16'd0;
    always @(posedge clk) begin
        d1 <= (addr >= BASE && addr < BASE + 18'(W)) ? mem[int'(addr - BASE)] : 16'hDEAD;
        d2 <= d1;
    end
    assign rdata = d2;

    // Pixel p is bytes 3p..3p+2 of the big-endian byte stream held in mem
    function automatic logic [23:0] pix(input int p);
        logic [7:0] b [3];
        for (int k = 0; k < 3; k++) begin
            int j = 3 * p + k;
            logic [15:0] w = mem[j / 2];
            b[k] = (j % 2 == 0) ? w[15:8] : w[7:0];
        end
        return {b[0], b[1], b[2]};
    endfunction

    logic [23:0] m_rgb;
    logic        m_uf, m_live;
    logic [15:0] m_ufc;
    int          m_idx;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_rgb <= 24'd0; m_uf <= 1'b0; m_live <= 1'b0; m_idx <= 0; m_ufc <= 16'd0;
        end else if (frame_start) begin
            m_live <= 1'b1; m_idx <= 0; m_uf <= 1'b0; m_ufc <= 16'd0;
        end else if (pixel_req) begin
            if (!m_live) m_rgb <= 24'd0;
            else if (req_under) begin
                m_rgb <= 24'd0; m_uf <= 1'b1;
                if (m_ufc != 16'hFFFF) m_ufc <= m_ufc + 16'd1;
            end else begin
                m_rgb <= pix(m_idx); m_idx <= m_idx + 1;
                if (m_idx == NPIX - 1) m_live <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rgb", 32'(rgb), 32'(m_rgb));
        chk("underflow", 32'(uf), 32'(m_uf));
        chk("busy", 32'(busy), 32'(m_live));
        chk("we_n", 32'(we_n), 32'd1);
        chk("addr_in_frame", 32'(addr >= BASE && addr <= BASE + 18'(W - 1)), 32'd1);
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
        chk("underflow_count", 32'(ufc), 32'(m_ufc));
`endif
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic pulse_fs();
        frame_start = 1'b1; tick(1); frame_start = 1'b0;
    endtask
    task automatic req(input logic u);
        pixel_req = 1'b1; req_under = u; tick(1); pixel_req = 1'b0; req_under = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < W; i++) mem[i] = 16'(i * 40503 + 7);
        mem[0] = 16'h1122; mem[1] = 16'h3344; mem[2] = 16'h5566;
        chk("model_pix0", 32'(pix(0)), 32'h112233);
        chk("model_pix1", 32'(pix(1)), 32'h445566);
        #1 resetn = 1'b0;
        tick(3);
        chk("rst_addr", 32'(addr), 32'(BASE));
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_uf", 32'(uf), 32'd0);
        chk("rst_ufc", 32'(ufc), 32'd0);
        resetn = 1'b1;
        tick(2);
        // unpack
        pulse_fs(); tick(9);
        req(1'b0); chk("unpack_p0", 32'(rgb), 32'h112233);
        tick(1);
        req(1'b0); chk("unpack_p1", 32'(rgb), 32'h445566);
        tick(3);
        chk("rgb_hold", 32'(rgb), 32'h445566);
        // prefetch cap
        pulse_fs(); tick(100);
        chk("cap_addr", 32'(addr), 32'(BASE + 18'd8));
        chk("cap_busy", 32'(busy), 32'd1);
        tick(20);
        chk("cap_addr_hold", 32'(addr), 32'(BASE + 18'd8));
        // underflow right after frame start
        pulse_fs();
        req(1'b1);
        chk("uf_rgb", 32'(rgb), 32'd0);
        chk("uf_flag", 32'(uf), 32'd1);
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
        chk("uf_count", 32'(ufc), 32'd1);
`endif
        tick(8);
        req(1'b0); chk("uf_then_p0", 32'(rgb), 32'h112233);
        chk("uf_sticky", 32'(uf), 32'd1);
        tick(1);
        // full frame
        pulse_fs(); tick(9);
        for (int i = 0; i < NPIX; i++) begin req(1'b0); tick(1); end
        chk("ff_busy", 32'(busy), 32'd0);
        chk("ff_last_addr", 32'(addr), 32'(BASE + 18'(W - 1)));
        chk("ff_uf", 32'(uf), 32'd0);
        req(1'b0); chk("idle_req_rgb", 32'(rgb), 32'd0);
        chk("idle_req_uf", 32'(uf), 32'd0);
        tick(1);
        // restart mid-frame with reads in flight
        pulse_fs(); req(1'b1); tick(8);
        for (int i = 0; i < 60; i++) begin req(1'b0); tick(1); end
        pulse_fs();
        chk("restart_uf_clr", 32'(uf), 32'd0);
        tick(9);
        req(1'b0); chk("restart_p0", 32'(rgb), 32'h112233);
        tick(1);
        req(1'b0); chk("restart_p1", 32'(rgb), 32'h445566);
        tick(1);
        for (int i = 0; i < 4; i++) begin req(1'b0); tick(1); end
        // async reset mid-fetch
        pulse_fs(); tick(5);
        resetn = 1'b0; #1;
        chk("arst_addr", 32'(addr), 32'(BASE));
        chk("arst_rgb", 32'(rgb), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick(3);
        resetn = 1'b1;
        tick(20);
        chk("arst_no_reads", 32'(addr), 32'(BASE));
        chk("arst_idle", 32'(busy), 32'd0);
        pulse_fs(); tick(9);
        req(1'b0); chk("arst_p0", 32'(rgb), 32'h112233);
        tick(1);
        req(1'b0); tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
